pipe_scoreboard: RTL and testbench

Parametrised hazard/bypass engine for the pipelined MIPS core. It replaces the fixed two-operand forwarding and stall logic with a scoreboard that tracks in-flight register writes across a configurable number of post-decode stages. It produces per-port forward selects, bypassed operands and a decode stall. It sits between decode (register file read) and execute, and serves any number of read ports and any data width.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_scoreboard_if.sv | 32 +++
 rtl/pipe_scoreboard_sb_match.sv | 42 ++++
 rtl/pipe_scoreboard.sv | 97 +++++++++
 tb/tb_pipe_scoreboard.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe_scoreboard hazard/bypass engine.
package pipe_pkg;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic       ld;
    logic [4:0] rd;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned STAGE_E = 0;
  localparam int unsigned STAGE_M = 1;
  localparam int unsigned STAGE_W = 2;

  // fwd_sel must encode 0 (register file) plus one code per tracked stage.
  function automatic int unsigned sel_width(input int unsigned depth);
    return (depth + 1 > 1) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Decode-side bus of pipe_scoreboard: issue slot, read ports, stage results and bypass outputs.
interface pipe_scoreboard_if
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned SELW = sel_width(DEPTH);

  logic                            issue_valid;
  logic                            issue_we;
  logic                            issue_ld;
  logic [4:0]                      issue_rd;
  logic [NRD-1:0][4:0]             rs;
  logic [NRD-1:0][XLEN-1:0]        rf_data;
  logic [DEPTH-1:0][XLEN-1:0]      stage_data;
  logic [NRD-1:0][XLEN-1:0]        operand;
  logic [NRD-1:0][SELW-1:0]        fwd_sel;
  logic                            stall;

  modport master (
    output issue_valid, issue_we, issue_ld, issue_rd, rs, rf_data, stage_data,
    input  operand, fwd_sel, stall
  );

  modport slave (
    input  issue_valid, issue_we, issue_ld, issue_rd, rs, rf_data, stage_data,
    output operand, fwd_sel, stall
  );

endinterface

// File: rtl/pipe_scoreboard_sb_match.sv
// Per-read-port hazard check: youngest matching in-flight write, readiness test and operand mux.
module sb_match
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned ALU_RDY = 1,
  parameter int unsigned LD_RDY  = 2,
  parameter int unsigned SELW    = 2
) (
  input  sb_entry_t [DEPTH-1:0]       entries,
  input  logic [4:0]                  rs,
  input  logic [XLEN-1:0]             rf_data,
  input  logic [DEPTH-1:0][XLEN-1:0]  stage_data,
  output logic [XLEN-1:0]             operand,
  output logic [SELW-1:0]             fwd_sel,
  output logic                        stall_req
);

  logic found;

  always_comb begin
    found     = 1'b0;
    operand   = rf_data;
    fwd_sel   = '0;
    stall_req = 1'b0;
    // Ascending scan with a found flag gives priority to the youngest stage.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found && entries[k].valid && entries[k].we &&
          entries[k].rd == rs && rs != REG_ZERO) begin
        found = 1'b1;
        if (k >= (entries[k].ld ? LD_RDY : ALU_RDY)) begin
          fwd_sel = SELW'(k + 1);
          operand = stage_data[k];
        end else begin
          stall_req = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Scoreboard hazard/bypass engine tracking in-flight register writes after decode.
// Optional SCOREBOARD_PERF_EN adds perf_stall_cnt / perf_fwd_cnt counters.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned ALU_RDY = 1,
  parameter int unsigned LD_RDY  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  pipe_scoreboard_if.slave  bus
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt
`endif
);

  localparam int unsigned SELW = sel_width(DEPTH);

  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [NRD-1:0]        stall_req;
  logic                  stall_c;
  logic                  issue_go;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    sb_match #(
      .XLEN   (XLEN),
      .DEPTH  (DEPTH),
      .ALU_RDY(ALU_RDY),
      .LD_RDY (LD_RDY),
      .SELW   (SELW)
    ) u_match (
      .entries   (entries_q),
      .rs        (bus.rs[i]),
      .rf_data   (bus.rf_data[i]),
      .stage_data(bus.stage_data),
      .operand   (bus.operand[i]),
      .fwd_sel   (bus.fwd_sel[i]),
      .stall_req (stall_req[i])
    );
  end

  assign stall_c   = (|stall_req) & bus.issue_valid & ~flush & ~hold;
  assign bus.stall = stall_c;
  assign issue_go  = bus.issue_valid & ~stall_c & ~flush & ~hold;

  always_comb begin
    entries_d = entries_q;
    if (!hold) begin
      for (int unsigned k = DEPTH - 1; k > 0; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = '0;
      if (issue_go) begin
        entries_d[0].valid = 1'b1;
        entries_d[0].we    = bus.issue_we && (bus.issue_rd != REG_ZERO);
        entries_d[0].ld    = bus.issue_ld;
        entries_d[0].rd    = bus.issue_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) entries_q <= '0;
    else        entries_q <= entries_d;
  end

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_c};
    fwd_cnt_d   = fwd_cnt_q + {31'd0, issue_go & (|bus.fwd_sel)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Self-checking bench for pipe_scoreboard: directed hazard scenarios plus randomized traffic vs an age-based model.
module tb_pipe_scoreboard;
  import pipe_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NRD     = 2;
  localparam int unsigned DEPTH   = 3;
  localparam int unsigned ALU_RDY = 1;
  localparam int unsigned LD_RDY  = 2;

  logic clk = 1'b0;
  logic reset;
  logic hold;
  logic flush;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pipe_scoreboard_if #(.XLEN(XLEN), .NRD(NRD), .DEPTH(DEPTH)) bus ();

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_fwd_cnt;
  logic [31:0] m_stall_cnt, m_fwd_cnt;
`endif

  pipe_scoreboard #(
    .XLEN(XLEN), .NRD(NRD), .DEPTH(DEPTH), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hold (hold),
    .flush(flush),
    .bus  (bus)
`ifdef SCOREBOARD_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_fwd_cnt  (perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: list of in-flight register writers, each tagged with its age in cycles since issue.
  typedef struct {
    bit          ld;
    logic [4:0]  rd;
    int unsigned age;
  } rec_t;

  rec_t            q[$];
  logic [XLEN-1:0] exp_op  [NRD];
  int unsigned     exp_sel [NRD];
  bit              exp_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    bit req = 0;
    for (int i = 0; i < NRD; i++) begin
      int unsigned best = DEPTH;
      bit          bld  = 0;
      foreach (q[j]) begin
        if (q[j].rd == bus.rs[i] && bus.rs[i] != 5'd0 && q[j].age < best) begin
          best = q[j].age;
          bld  = q[j].ld;
        end
      end
      exp_sel[i] = 0;
      exp_op[i]  = bus.rf_data[i];
      if (best < DEPTH) begin
        if (best >= (bld ? LD_RDY : ALU_RDY)) begin
          exp_sel[i] = best + 1;
          exp_op[i]  = bus.stage_data[best];
        end else begin
          req = 1;
        end
      end
    end
    exp_stall = req && bus.issue_valid && !flush && !hold;
  endtask

  task automatic model_advance();
    rec_t nq[$];
    bit   issued;
    bit   any_fwd;
    if (!reset) begin
      q.delete();
`ifdef SCOREBOARD_PERF_EN
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
`endif
      return;
    end
    issued  = bus.issue_valid && !exp_stall && !flush && !hold;
    any_fwd = 0;
    for (int i = 0; i < NRD; i++) if (exp_sel[i] != 0) any_fwd = 1;
`ifdef SCOREBOARD_PERF_EN
    m_stall_cnt += {31'd0, exp_stall};
    m_fwd_cnt   += {31'd0, issued && any_fwd};
`endif
    if (hold) return;
    foreach (q[j]) begin
      if (q[j].age + 1 < DEPTH) begin
        rec_t r;
        r = q[j];
        r.age++;
        nq.push_back(r);
      end
    end
    if (issued && bus.issue_we && bus.issue_rd != 5'd0) begin
      rec_t r;
      r.ld  = bus.issue_ld;
      r.rd  = bus.issue_rd;
      r.age = 0;
      nq.push_back(r);
    end
    q = nq;
  endtask

  task automatic step();
    #1;
    model_eval();
    check("stall", {63'd0, bus.stall}, {63'd0, exp_stall});
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("fwd_sel%0d", i), 64'(bus.fwd_sel[i]), 64'(exp_sel[i]));
      check($sformatf("operand%0d", i), 64'(bus.operand[i]), 64'(exp_op[i]));
    end
`ifdef SCOREBOARD_PERF_EN
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall_cnt));
    check("perf_fwd_cnt", 64'(perf_fwd_cnt), 64'(m_fwd_cnt));
`endif
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_issue(input bit v, input bit we, input bit ld, input logic [4:0] rd);
    bus.issue_valid = v;
    bus.issue_we    = we;
    bus.issue_ld    = ld;
    bus.issue_rd    = rd;
  endtask

  task automatic set_rs(input logic [4:0] r0, input logic [4:0] r1);
    bus.rs[0] = r0;
    bus.rs[1] = r1;
  endtask

  initial begin
    reset = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    set_issue(0, 0, 0, 5'd0);
    set_rs(5'd5, 5'd6);
    bus.rf_data[0]    = 32'h11;
    bus.rf_data[1]    = 32'h22;
    bus.stage_data[0] = 32'hE0E0;
    bus.stage_data[1] = 32'hDEAD;
    bus.stage_data[2] = 32'hBEEF;
`ifdef SCOREBOARD_PERF_EN
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    #1;
    check("rst_op0", 64'(bus.operand[0]), 64'h11);
    check("rst_op1", 64'(bus.operand[1]), 64'h22);
    check("rst_sel0", 64'(bus.fwd_sel[0]), 64'd0);
    check("rst_sel1", 64'(bus.fwd_sel[1]), 64'd0);
    check("rst_stall", {63'd0, bus.stall}, 64'd0);
    step();

    // ALU-use: one stall cycle, then forward from M
    set_issue(1, 1, 0, 5'd8); set_rs(5'd1, 5'd2); step();
    set_issue(1, 1, 0, 5'd11); set_rs(5'd8, 5'd2);
    #1 check("alu_stall", {63'd0, bus.stall}, 64'd1);
    step();
    #1;
    check("alu_stall_done", {63'd0, bus.stall}, 64'd0);
    check("alu_sel0", 64'(bus.fwd_sel[0]), 64'd2);
    check("alu_op0", 64'(bus.operand[0]), 64'hDEAD);
    step();

    // Load-use: two stall cycles, then forward from W
    set_issue(1, 1, 1, 5'd9); set_rs(5'd1, 5'd2); step();
    set_issue(1, 1, 0, 5'd13); set_rs(5'd3, 5'd9);
    for (int c = 0; c < 2; c++) begin
      #1 check($sformatf("ld_stall_c%0d", c), {63'd0, bus.stall}, 64'd1);
      step();
    end
    #1;
    check("ld_stall_done", {63'd0, bus.stall}, 64'd0);
    check("ld_sel1", 64'(bus.fwd_sel[1]), 64'd3);
    check("ld_op1", 64'(bus.operand[1]), 64'hBEEF);
    step();

    // Two writers of $10 in flight: youngest wins
    set_issue(1, 1, 0, 5'd10); set_rs(5'd1, 5'd2); step();
    set_issue(1, 1, 0, 5'd10); step();
    set_issue(0, 0, 0, 5'd0); step();
    set_issue(1, 0, 0, 5'd0); set_rs(5'd10, 5'd2);
    #1;
    check("young_sel0", 64'(bus.fwd_sel[0]), 64'd2);
    check("young_op0", 64'(bus.operand[0]), 64'hDEAD);
    step();

    // $0 is never pending
    set_issue(1, 1, 0, 5'd0); set_rs(5'd1, 5'd2); step();
    set_issue(1, 0, 0, 5'd0); set_rs(5'd0, 5'd0);
    #1;
    check("r0_stall", {63'd0, bus.stall}, 64'd0);
    check("r0_sel0", 64'(bus.fwd_sel[0]), 64'd0);
    check("r0_op0", 64'(bus.operand[0]), 64'h11);
    step();

    // Flush beats stall, hold freezes, async reset clears
    set_issue(1, 1, 1, 5'd12); set_rs(5'd1, 5'd2); step();
    set_issue(1, 1, 0, 5'd14); set_rs(5'd12, 5'd2);
    flush = 1'b1;
    #1 check("flush_stall", {63'd0, bus.stall}, 64'd0);
    step();
    flush = 1'b0;
    hold  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check($sformatf("hold_stall_c%0d", c), {63'd0, bus.stall}, 64'd0);
      step();
    end
    hold = 1'b0;
    #1 check("hold_frozen_stall", {63'd0, bus.stall}, 64'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_stall", {63'd0, bus.stall}, 64'd0);
    check("rst_mid_sel0", 64'(bus.fwd_sel[0]), 64'd0);
    q.delete();
`ifdef SCOREBOARD_PERF_EN
    m_stall_cnt = 0;
    m_fwd_cnt   = 0;
`endif
    step();
    reset = 1'b1;
    step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      set_issue($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
      set_rs(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      flush = ($urandom_range(0, 11) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NRD; i++) bus.rf_data[i] = $urandom;
      for (int k = 0; k < DEPTH; k++) bus.stage_data[k] = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        q.delete();
`ifdef SCOREBOARD_PERF_EN
        m_stall_cnt = 0;
        m_fwd_cnt   = 0;
`endif
      end else begin
        reset = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
